// File: rtl/decode_scoreboard.sv
// Decode-stage register scoreboard: per-GPR pending-write counters, RAW/WAW/fence.i hold, inflight tracking.
// Optional CSR pending counter enabled by defining SCOREBOARD_CSR_EN.
module decode_scoreboard (
  input  logic       clock,
  input  logic       reset,
  input  logic       issue_fire_i,
  input  logic       issue_wena_i,
  input  logic [4:0] issue_waddr_i,
  input  logic       issue_csr_wena_i,
  input  logic       rena1_i,
  input  logic [4:0] raddr1_i,
  input  logic       rena2_i,
  input  logic [4:0] raddr2_i,
  input  logic       csr_rena_i,
  input  logic       fencei_i,
  input  logic       commit_wena_i,
  input  logic [4:0] commit_waddr_i,
  input  logic       commit_csr_wena_i,
  output logic       hazard_o,
  output logic       busy_o,
  output logic [3:0] inflight_o,
  output logic       err_o
);

  localparam logic [3:0] INFLIGHT_MAX = 4'd15;
  localparam logic [1:0] CNT_MAX      = 2'd3;

  // Entry 0 exists only to keep indexing simple; it is held at zero.
  logic [31:0][1:0] cnt_q, cnt_d;
  logic [3:0]       inflight_q, inflight_d;
  logic             err_q, err_d;

  logic src1_pending, src2_pending, dest_full, fence_wait, inflight_full;
  logic csr_hazard, csr_underflow;
  logic issue_ok, gpr_inc, gpr_cmt, gpr_dec, gpr_underflow;
  logic inf_inc, inf_dec;

`ifdef SCOREBOARD_CSR_EN
  logic [1:0] csr_cnt_q, csr_cnt_d;
  logic       csr_inc, csr_dec;
`else
  logic unused_csr;
  assign unused_csr = csr_rena_i;
`endif

  assign busy_o     = (inflight_q != 4'd0);
  assign inflight_o = inflight_q;
  assign err_o      = err_q;

  // Hazard looks only at registered counters: a commit in this cycle is not bypassed.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    src1_pending  = 1'b0;
    src2_pending  = 1'b0;
    dest_full     = 1'b0;
    csr_hazard    = 1'b0;
    if (rena1_i && (raddr1_i != 5'd0))
      src1_pending = (cnt_q[raddr1_i] != 2'd0);
    if (rena2_i && (raddr2_i != 5'd0))
      src2_pending = (cnt_q[raddr2_i] != 2'd0);
    if (issue_wena_i && (issue_waddr_i != 5'd0))
      dest_full = (cnt_q[issue_waddr_i] == CNT_MAX);
    fence_wait    = fencei_i && busy_o;
    inflight_full = (inflight_q == INFLIGHT_MAX);
`ifdef SCOREBOARD_CSR_EN
    csr_hazard = (csr_rena_i && (csr_cnt_q != 2'd0)) ||
                 (issue_csr_wena_i && (csr_cnt_q == CNT_MAX));
`endif
    hazard_o = src1_pending || src2_pending || dest_full || fence_wait ||
               inflight_full || csr_hazard;
  end

  always_comb begin
    issue_ok      = issue_fire_i && !hazard_o;
    gpr_inc       = issue_ok && issue_wena_i && (issue_waddr_i != 5'd0);
    gpr_cmt       = commit_wena_i && (commit_waddr_i != 5'd0);
    gpr_dec       = gpr_cmt && (cnt_q[commit_waddr_i] != 2'd0);
    gpr_underflow = gpr_cmt && (cnt_q[commit_waddr_i] == 2'd0);

    cnt_d    = cnt_q;
    cnt_d[0] = 2'd0;
    for (int r = 1; r < 32; r++) begin
      case ({gpr_inc && (issue_waddr_i == 5'(r)), gpr_dec && (commit_waddr_i == 5'(r))})
        2'b10:   if (cnt_q[r] != CNT_MAX) cnt_d[r] = cnt_q[r] + 2'd1;
        2'b01:   cnt_d[r] = cnt_q[r] - 2'd1;
        default: cnt_d[r] = cnt_q[r];
      endcase
    end

    csr_underflow = 1'b0;
`ifdef SCOREBOARD_CSR_EN
    csr_inc       = issue_ok && issue_csr_wena_i;
    csr_dec       = commit_csr_wena_i && (csr_cnt_q != 2'd0);
    csr_underflow = commit_csr_wena_i && (csr_cnt_q == 2'd0);
    csr_cnt_d     = csr_cnt_q;
    case ({csr_inc, csr_dec})
      2'b10:   if (csr_cnt_q != CNT_MAX) csr_cnt_d = csr_cnt_q + 2'd1;
      2'b01:   csr_cnt_d = csr_cnt_q - 2'd1;
      default: csr_cnt_d = csr_cnt_q;
    endcase
`endif

    // Counts every writing instruction, including x0 and CSR-only writes; saturates at both ends.
    inf_inc    = issue_ok && (issue_wena_i || issue_csr_wena_i);
    inf_dec    = commit_wena_i || commit_csr_wena_i;
    inflight_d = inflight_q;
    if (inf_inc && !inf_dec && (inflight_q != INFLIGHT_MAX))
      inflight_d = inflight_q + 4'd1;
    else if (inf_dec && !inf_inc && (inflight_q != 4'd0))
      inflight_d = inflight_q - 4'd1;

    err_d = err_q || (issue_fire_i && hazard_o) || gpr_underflow || csr_underflow;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the counter array must be reset, since stale pending counts would stall decode forever.
      cnt_q      <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples its pre-edge value.
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

`ifdef SCOREBOARD_CSR_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) csr_cnt_q <= '0;
    else        csr_cnt_q <= csr_cnt_d;
  end
`endif

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed scoreboard bench for decode_scoreboard; expectations queued with each step, checked at the falling edge.
module tb_decode_scoreboard;

  logic       clock = 1'b0;
  logic       reset;
  logic       issue_fire_i, issue_wena_i, issue_csr_wena_i;
  logic [4:0] issue_waddr_i;
  logic       rena1_i, rena2_i, csr_rena_i, fencei_i;
  logic [4:0] raddr1_i, raddr2_i;
  logic       commit_wena_i, commit_csr_wena_i;
  logic [4:0] commit_waddr_i;
  logic       hazard_o, busy_o, err_o;
  logic [3:0] inflight_o;

`ifdef SCOREBOARD_CSR_EN
  localparam logic CSR_H = 1'b1;
`else
  localparam logic CSR_H = 1'b0;
`endif

  typedef struct {
    string      tag;
    logic       hazard;
    logic       busy;
    logic [3:0] inflight;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_err    = 0;
  int   n_checks = 0;

  decode_scoreboard dut (
    .clock            (clock),
    .reset            (reset),
    .issue_fire_i     (issue_fire_i),
    .issue_wena_i     (issue_wena_i),
    .issue_waddr_i    (issue_waddr_i),
    .issue_csr_wena_i (issue_csr_wena_i),
    .rena1_i          (rena1_i),
    .raddr1_i         (raddr1_i),
    .rena2_i          (rena2_i),
    .raddr2_i         (raddr2_i),
    .csr_rena_i       (csr_rena_i),
    .fencei_i         (fencei_i),
    .commit_wena_i    (commit_wena_i),
    .commit_waddr_i   (commit_waddr_i),
    .commit_csr_wena_i(commit_csr_wena_i),
    .hazard_o         (hazard_o),
    .busy_o           (busy_o),
    .inflight_o       (inflight_o),
    .err_o            (err_o)
  );

  always #5 clock = ~clock;

  task automatic clear_inputs();
    issue_fire_i = 0; issue_wena_i = 0; issue_waddr_i = 0; issue_csr_wena_i = 0;
    rena1_i = 0; raddr1_i = 0; rena2_i = 0; raddr2_i = 0;
    csr_rena_i = 0; fencei_i = 0;
    commit_wena_i = 0; commit_waddr_i = 0; commit_csr_wena_i = 0;
  endtask

  task automatic push_exp(input string tag, input logic h, input logic b,
                          input logic [3:0] n, input logic e);
    exp_t x;
    x.tag = tag; x.hazard = h; x.busy = b; x.inflight = n; x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic compare_head();
    exp_t x;
    x = exp_q.pop_front();
    n_checks++;
    assert (hazard_o === x.hazard) else begin
      n_err++;
      $error("FAIL %s hazard_o observed=%b expected=%b", x.tag, hazard_o, x.hazard);
    end
    n_checks++;
    assert (busy_o === x.busy) else begin
      n_err++;
      $error("FAIL %s busy_o observed=%b expected=%b", x.tag, busy_o, x.busy);
    end
    n_checks++;
    assert (inflight_o === x.inflight) else begin
      n_err++;
      $error("FAIL %s inflight_o observed=%0d expected=%0d", x.tag, inflight_o, x.inflight);
    end
    n_checks++;
    assert (err_o === x.err) else begin
      n_err++;
      $error("FAIL %s err_o observed=%b expected=%b", x.tag, err_o, x.err);
    end
  endtask

  // Inputs are already driven; check at the falling edge, then let the rising edge update state.
  task automatic step(input string tag, input logic h, input logic b,
                      input logic [3:0] n, input logic e);
    push_exp(tag, h, b, n, e);
    @(negedge clock);
    compare_head();
    @(posedge clock);
    #1;
    clear_inputs();
  endtask

  task automatic issue(input logic [4:0] a);
    issue_fire_i = 1; issue_wena_i = 1; issue_waddr_i = a;
  endtask

  task automatic commit(input logic [4:0] a);
    commit_wena_i = 1; commit_waddr_i = a;
  endtask

  task automatic read1(input logic [4:0] a);
    rena1_i = 1; raddr1_i = a;
  endtask

  task automatic pulse_reset();
    reset = 0;
    @(posedge clock);
    #1;
    reset = 1;
  endtask

  initial begin
    clear_inputs();
    reset = 0;
    @(posedge clock);
    #1;
    step("reset_state", 0, 0, 4'd0, 0);
    reset = 1;
    step("after_reset", 0, 0, 4'd0, 0);

    // RAW on x5
    issue(5);            step("issue_x5", 0, 0, 4'd0, 0);
    read1(5);            step("raw_x5_hold", 1, 1, 4'd1, 0);
    read1(5); commit(5); step("raw_x5_same_cycle_commit", 1, 1, 4'd1, 0);
    read1(5);            step("raw_x5_release", 0, 0, 4'd0, 0);

    // WAW saturation on x7
    issue(7);            step("issue_x7_a", 0, 0, 4'd0, 0);
    issue(7);            step("issue_x7_b", 0, 1, 4'd1, 0);
    issue(7);            step("issue_x7_c", 0, 1, 4'd2, 0);
    issue_wena_i = 1; issue_waddr_i = 7;
    step("waw_x7_full", 1, 1, 4'd3, 0);
    issue_wena_i = 1; issue_waddr_i = 7; commit(7);
    step("waw_x7_commit", 1, 1, 4'd3, 0);
    issue_wena_i = 1; issue_waddr_i = 7;
    step("waw_x7_release", 0, 1, 4'd2, 0);
    commit(7);           step("drain_x7_a", 0, 1, 4'd2, 0);
    commit(7);           step("drain_x7_b", 0, 1, 4'd1, 0);

    // Same-cycle issue and commit on x3
    issue(3);            step("issue_x3", 0, 0, 4'd0, 0);
    issue(3); commit(3); step("x3_issue_commit", 0, 1, 4'd1, 0);
    read1(3);            step("x3_still_pending", 1, 1, 4'd1, 0);
    read1(3); commit(3); step("x3_commit", 1, 1, 4'd1, 0);
    read1(3);            step("x3_clear", 0, 0, 4'd0, 0);

    // Underflow on x9, writes to x0
    commit(9);           step("commit_x9_empty", 0, 0, 4'd0, 0);
    read1(9);            step("x9_err_sticky", 0, 0, 4'd0, 1);
    issue(0);            step("issue_x0", 0, 0, 4'd0, 1);
    read1(0); rena2_i = 1; raddr2_i = 0;
    step("x0_no_hazard", 0, 1, 4'd1, 1);
    commit(0);           step("commit_x0", 0, 1, 4'd1, 1);
    step("x0_drained", 0, 0, 4'd0, 1);

    // fence.i waits for two outstanding writes
    issue(10);           step("issue_x10", 0, 0, 4'd0, 1);
    issue(11);           step("issue_x11", 0, 1, 4'd1, 1);
    fencei_i = 1;        step("fencei_wait", 1, 1, 4'd2, 1);
    fencei_i = 1; commit(10); step("fencei_commit_x10", 1, 1, 4'd2, 1);
    fencei_i = 1; commit(11); step("fencei_commit_x11", 1, 1, 4'd1, 1);
    fencei_i = 1;        step("fencei_release", 0, 0, 4'd0, 1);

    // Asynchronous reset mid-stream, then stale commit
    issue(12);           step("issue_x12", 0, 0, 4'd0, 1);
    issue(13);           step("issue_x13", 0, 1, 4'd1, 1);
    read1(12); fencei_i = 1;
    reset = 0;
    #2;
    push_exp("async_reset", 0, 0, 4'd0, 0);
    compare_head();
    @(posedge clock);
    #1;
    reset = 1;
    clear_inputs();
    commit(12);          step("stale_commit_x12", 0, 0, 4'd0, 0);
    step("stale_commit_err", 0, 0, 4'd0, 1);

    // CSR pending write
    issue_fire_i = 1; issue_csr_wena_i = 1;
    step("issue_csr", 0, 0, 4'd0, 1);
    csr_rena_i = 1;      step("csr_read_pending", CSR_H, 1, 4'd1, 1);
    csr_rena_i = 1; commit_csr_wena_i = 1;
    step("csr_commit", CSR_H, 1, 4'd1, 1);
    csr_rena_i = 1;      step("csr_clear", 0, 0, 4'd0, 1);

    // Fill inflight to 15, rejected fire, then drain
    pulse_reset();
    for (int i = 0; i < 15; i++) begin
      issue(0);
      step("fill_inflight", 0, (i != 0), 4'(i), 0);
    end
    issue(0);            step("inflight_full_fire", 1, 1, 4'd15, 0);
    commit(0);           step("inflight_full_err", 1, 1, 4'd15, 1);
    for (int i = 14; i > 0; i--) begin
      commit(0);
      step("drain_inflight", 0, 1, 4'(i), 1);
    end
    step("inflight_empty", 0, 0, 4'd0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
